// File: rtl/mult_pkg.sv
// Shared constants and controller strobe bundle for the shift-add multiplier.
package mult_pkg;

  localparam int unsigned MULT_WIDTH = 32;
  localparam int unsigned CNT_W      = $clog2(MULT_WIDTH + 1);

  typedef struct packed {
    logic lm;
    logic lp;
    logic sm;
    logic count;
  } mult_ctrl_t;

endpackage

// File: rtl/mult_if.sv
// Controller <-> datapath bundle: strobes and operands in, product and done back.
interface mult_if
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_WIDTH
);

  mult_ctrl_t             ctrl;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic [2*WIDTH-1:0]     product;
  logic                   done;

  modport master (output ctrl, output a, output b, input product, input done);
  modport slave  (input ctrl, input a, input b, output product, output done);

endinterface

// File: rtl/mult_iter_counter.sv
// Saturating iteration counter and registered done flag for mult_datapath.
module mult_iter_counter
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic count,
  input  logic early_done,
  output logic done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [CW-1:0] iter;

  // Load restarts the count; once done is set, strobes are ignored until reload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iter <= '0;
      done <= 1'b0;
    end else if (load) begin
      iter <= '0;
      done <= early_done;
    end else if (!done) begin
      if (count && (iter != CW'(WIDTH)))
        iter <= iter + CW'(1);
      if ((count && (iter == CW'(WIDTH - 1))) || early_done)
        done <= 1'b1;
    end
  end

endmodule

// File: rtl/mult_datapath.sv
// Shift-add multiplier datapath driven by an external controller.
// Define MULT_EARLY_DONE_EN to finish as soon as the multiplier runs out of set bits.
module mult_datapath
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_WIDTH
) (
  input logic   clk,
  input logic   rst,
  mult_if.slave bus
);

  localparam int unsigned PW = 2 * WIDTH;

  mult_ctrl_t       ctrl;
  logic [PW-1:0]    mcand;
  logic [PW-1:0]    product;
  logic [WIDTH-1:0] mplier;
  logic             done;
  logic             load_c;
  logic             step_c;
  logic             early_c;

  assign ctrl   = bus.ctrl;
  // lm together with lp is an accumulate cycle, never a load.
  assign load_c = ctrl.lm && !ctrl.lp;
  assign step_c = !load_c && !done;

`ifdef MULT_EARLY_DONE_EN
  assign early_c = load_c ? (bus.b == '0)
                          : (step_c && ctrl.sm && (mplier[WIDTH-1:1] == '0));
`else
  assign early_c = 1'b0;
`endif

  // Accumulate sees pre-shift operands; both commit on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
    end else if (load_c) begin
      mcand   <= PW'(bus.a);
      mplier  <= bus.b;
      product <= '0;
    end else if (step_c) begin
      if (ctrl.lp && mplier[0])
        product <= product + mcand;
      if (ctrl.sm) begin
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
      end
    end
  end

  mult_iter_counter #(.WIDTH(WIDTH)) u_iter (
    .clk        (clk),
    .rst        (rst),
    .load       (load_c),
    .count      (ctrl.count),
    .early_done (early_c),
    .done       (done)
  );

  assign bus.product = product;
  assign bus.done    = done;

endmodule

// File: tb/tb_mult_datapath.sv
// Scoreboard bench for mult_datapath: expected products queued at load, checked at done.
`timescale 1ns/1ps
module tb_mult_datapath;
  import mult_pkg::*;

  localparam int unsigned W  = 32;
  localparam int unsigned PW = 2 * W;

  logic clk = 1'b0;
  logic rst;

  mult_if #(.WIDTH(W)) bus ();

  mult_datapath #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [PW-1:0] sb[$];

  task automatic cyc(input logic lm, input logic lp, input logic sm, input logic cnt,
                     input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.ctrl = '{lm: lm, lp: lp, sm: sm, count: cnt};
    bus.a    = a;
    bus.b    = b;
    @(posedge clk);
    #1;
    bus.ctrl = '0;
  endtask

  task automatic load_op(input logic [W-1:0] a, input logic [W-1:0] b);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, a, b);
    sb.push_back(PW'(a) * PW'(b));
  endtask

  task automatic step();
    cyc(1'b0, 1'b1, 1'b1, 1'b1, '0, '0);
  endtask

  // Run strobes until done (bounded), then check the scoreboard head and latency.
  task automatic finish_op(input string name, input int already);
    logic [PW-1:0] exp;
    int n;
    n = already;
    while (bus.done !== 1'b1 && n < int'(PW)) begin
      step();
      n++;
    end
    tests++;
    if (bus.done !== 1'b1) begin
      fails++;
      $display("FAIL %s_done: got %b want 1", name, bus.done);
    end
    exp = sb.pop_front();
    tests++;
    if (bus.product !== exp) begin
      fails++;
      $display("FAIL %s_product: got %h want %h", name, bus.product, exp);
    end
`ifndef MULT_EARLY_DONE_EN
    tests++;
    if (n != int'(W)) begin
      fails++;
      $display("FAIL %s_latency: got %0d want %0d", name, n, W);
    end
`endif
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input string name);
    load_op(a, b);
    finish_op(name, 0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.ctrl = '0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (bus.product !== '0 || bus.done !== 1'b0) begin
      fails++;
      $display("FAIL reset: got product=%h done=%b want 0/0", bus.product, bus.done);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    run_op(32'd3, 32'd5, "basic");
    tests++;
    if (bus.product !== 64'd15) begin
      fails++;
      $display("FAIL basic_const: got %h want 15", bus.product);
    end
  endtask

  task automatic test_full_scale();
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, "full");
  endtask

  task automatic test_hold();
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if (bus.product !== 64'hFFFF_FFFE_0000_0001 || bus.done !== 1'b1) begin
        fails++;
        $display("FAIL hold%0d: got product=%h done=%b want fffffffe00000001/1",
                 i, bus.product, bus.done);
      end
    end
  endtask

  task automatic test_async_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1234, 32'h0000_FFFF);
    repeat (10) step();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    tests++;
    if (bus.product !== '0 || bus.done !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: got product=%h done=%b want 0/0", bus.product, bus.done);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if (bus.product !== '0 || bus.done !== 1'b0) begin
        fails++;
        $display("FAIL post_reset_idle%0d: got product=%h done=%b want 0/0",
                 i, bus.product, bus.done);
      end
    end
    run_op(32'd7, 32'd6, "reload");
    tests++;
    if (bus.product !== 64'd42) begin
      fails++;
      $display("FAIL reload_const: got %h want 42", bus.product);
    end
  endtask

  task automatic test_lm_lp();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd5, 32'd3);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'd100, 32'd100);
    tests++;
    if (bus.product !== 64'd5) begin
      fails++;
      $display("FAIL lm_lp_accum: got %h want 5", bus.product);
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
    tests++;
    if (bus.product !== 64'd15) begin
      fails++;
      $display("FAIL lm_lp_followup: got %h want 15", bus.product);
    end
  endtask

  task automatic test_early_done();
    logic exp_done;
`ifdef MULT_EARLY_DONE_EN
    exp_done = 1'b1;
`else
    exp_done = 1'b0;
`endif
    load_op(32'd9, 32'd1);
    step();
    tests++;
    if (bus.done !== exp_done || bus.product !== 64'd9) begin
      fails++;
      $display("FAIL early_first: got done=%b product=%h want %b/9",
               bus.done, bus.product, exp_done);
    end
    finish_op("early", 1);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    run_op(32'd0, 32'h1234_5678, "a_zero");
    run_op(32'hDEAD_BEEF, 32'd0, "b_zero");
    run_op(32'd1, 32'h8000_0000, "msb_mplier");
    run_op(32'h8000_0000, 32'h8000_0000, "msb_both");
    // Abandon an operation mid-flight; the new load must restart cleanly.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd12, 32'd13);
    repeat (5) step();
    run_op(32'd21, 32'd2, "abort_restart");
    for (int i = 0; i < 3; i++) begin
      ra = $urandom();
      rb = $urandom();
      run_op(ra, rb, "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_scale();
    test_hold();
    test_async_reset();
    test_lm_lp();
    test_early_done();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mult_datapath.md
MULT_DATAPATH -- requirements
Module: mult_datapath

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 lm  input  1  load operands; a 1-cycle strobe from the multiply controller.
REQ-005 lp  input  1  product accumulate strobe from the controller.
REQ-006 sm  input  1  shift multiplicand/multiplier strobe from the controller.
REQ-007 count  input  1  iteration counter increment strobe from the controller.
REQ-008 a  input  WIDTH  multiplicand operand, sampled on load.
REQ-009 b  input  WIDTH  multiplier operand, sampled on load.
REQ-010 product  output  2*WIDTH  accumulated product register.
REQ-011 done  output  1  registered completion flag, fed back to the controller.

Function
REQ-012 Internal registers SHALL be: mcand (2*WIDTH), mplier (WIDTH), product (2*WIDTH), iter counter (clog2(WIDTH+1) bits) and done.
REQ-013 Load (lm=1, lp=0) SHALL set mcand<=zero-extended a, mplier<=b, product<=0, iter<=0 and done<=0 at the next edge.
REQ-014 When lm=1 and lp=1 together, the cycle SHALL be treated as accumulate only; no load occurs.
REQ-015 Accumulate (lp=1) SHALL set product<=product+mcand if mplier[0]=1, else leave product unchanged; the sum is modulo 2^(2*WIDTH).
REQ-016 Shift (sm=1) SHALL set mcand<=mcand<<1 and mplier<=mplier>>1, with zero fill.
REQ-017 When lp and sm are in the same cycle, the accumulate SHALL use the pre-shift mcand/mplier values, and both updates SHALL commit at the same edge.
REQ-018 count=1 SHALL increment iter by 1; iter SHALL saturate at WIDTH.
REQ-019 done SHALL be set at the edge where iter transitions to WIDTH, so it is visible 1 cycle after the WIDTH-th count strobe.
REQ-020 done SHALL stay high until the next load or reset.
REQ-021 While done=1, lp, sm and count SHALL be ignored, and product SHALL be held stable.
REQ-022 A load while an operation is in progress (done=0, iter>0) SHALL abort it and restart per REQ-013.
REQ-023 product SHALL be a direct register output with no combinational path from any input.
REQ-024 Full-operation latency: WIDTH accumulate+shift+count steps; the result is valid when done=1.

Reset
REQ-025 Asserting rst SHALL immediately clear mcand, mplier, product and iter to 0 and done to 0, independent of clk.
REQ-026 Reset asserted mid-operation SHALL discard all partial state.
REQ-027 After rst deasserts, no operation SHALL proceed until a load occurs.

Configuration
REQ-028 Macro MULT_EARLY_DONE_EN SHALL control early termination.
REQ-029 With MULT_EARLY_DONE_EN defined, done SHALL also set at the edge where mplier becomes 0 after a shift, or at the edge after a load with b=0; product is final at that point.
REQ-030 Without MULT_EARLY_DONE_EN, done SHALL depend only on iter reaching WIDTH (REQ-019).

Structure
REQ-031 Package mult_pkg SHALL hold: the WIDTH default constant, CNT_W = clog2(WIDTH+1), and the control-strobe bundle typedef (lm, lp, sm, count) shared with the multiply controller.
REQ-032 The iteration counter, including saturation and the done-generation logic, SHALL be a sub-module named mult_iter_counter.
REQ-033 All other logic SHALL be flat within mult_datapath.

Verification
REQ-034 Basic product: load a=3, b=5, then 32 cycles of {lp,sm,count} -> product=15, done rises 1 cycle after the 32nd count.
REQ-035 Full-scale operands: a=b=0xFFFFFFFF, full sequence -> product=0xFFFFFFFE00000001, done=1.
REQ-036 Hold after done: 3 extra {lp,sm,count} cycles after done -> product and done unchanged.
REQ-037 Async reset mid-operation: assert rst after 10 iterations between clock edges -> product=0, done=0 immediately; a reload of a=7, b=6 then yields 42.
REQ-038 Same-cycle lm and lp: drive lm=1 with lp=1 -> operands not loaded, accumulate performed on existing registers.
REQ-039 Early done (MULT_EARLY_DONE_EN defined): a=9, b=1 -> done=1 after the first shift, product=9; without the macro, done is set only after 32 counts, and product is still 9.
